// File: rtl/ecc_scrub_mem_ctrl.sv
// SECDED-protected single-port memory controller with a valid/ready request port, a fixed
// read latency, correct-on-read writeback, a background scrubber and saturating error counters.
module ecc_scrub_mem_ctrl #(
  parameter  int DATA_WIDTH     = 8,
  parameter  int ADDR_WIDTH     = 5,
  parameter  int READ_LATENCY   = 2,
  parameter  int SCRUB_INTERVAL = 64,
  parameter  int CNT_WIDTH      = 8,
  localparam int CODE_WIDTH     = DATA_WIDTH + $clog2(DATA_WIDTH) + 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic                  i_inj_en,
  input  logic [CODE_WIDTH-1:0] i_inj_mask,
  input  logic                  i_scrub_en,
  input  logic                  i_cnt_clr,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]            o_rsp_err,
  output logic [CNT_WIDTH-1:0]  o_ce_count,
  output logic [CNT_WIDTH-1:0]  o_ue_count,
  output logic                  o_busy
);

  // state     | meaning
  // S_IDLE    | accept host requests, launch scrubs when due
  // S_RD_WAIT | host read in flight; response in last latency cycle
  // S_RD_WB   | write corrected word back after a host CE
  // S_SC_WAIT | scrub read in flight, no response
  // S_SC_WB   | write corrected word back after a scrub CE
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_RD_WB   = 3'd2;
  localparam logic [2:0] S_SC_WAIT = 3'd3;
  localparam logic [2:0] S_SC_WB   = 3'd4;

  localparam int PW    = $clog2(DATA_WIDTH) + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = $clog2(READ_LATENCY + 1);
  localparam int SW    = $clog2(SCRUB_INTERVAL);

  // Hamming positions 1..CODE_WIDTH-1 (check bits at powers of two), overall parity in bit 0
  function automatic logic [CODE_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [CODE_WIDTH-1:0] c;
    int j;
    c = '0;
    j = 0;
    for (int i = 1; i < CODE_WIDTH; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < PW; k++) begin
      for (int i = 1; i < CODE_WIDTH; i++) begin
        if (((i & (1 << k)) != 0) && (i != (1 << k))) c[1 << k] = c[1 << k] ^ c[i];
      end
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extract(input logic [CODE_WIDTH-1:0] c);
    logic [DATA_WIDTH-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CODE_WIDTH; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  logic [CODE_WIDTH-1:0] mem_q [DEPTH];

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [SW-1:0]         ivl_q, ivl_d;
  logic [CNT_WIDTH-1:0]  ce_q, ce_d, ue_q, ue_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;

  logic [CODE_WIDTH-1:0] rd_cw, fix_cw;
  logic [PW-1:0]         syn;
  logic                  par, is_ce, is_ue;
  logic [DATA_WIDTH-1:0] fix_data, dec_data;
  logic                  lat_done, scrub_due, rsp_fire, chk_fire;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [CODE_WIDTH-1:0] mem_wdata;

  always_comb begin
    rd_cw = mem_q[addr_q];
    syn   = '0;
    for (int i = 1; i < CODE_WIDTH; i++) begin
      if (rd_cw[i]) syn = syn ^ PW'(i);
    end
    par    = ^rd_cw;
    fix_cw = rd_cw;
    is_ce  = 1'b0;
    is_ue  = 1'b0;
    if (par) begin
      // an odd-parity syndrome pointing past the codeword cannot be a single flip
      if (int'(syn) < CODE_WIDTH) begin
        is_ce       = 1'b1;
        fix_cw[syn] = ~rd_cw[syn];
      end else begin
        is_ue = 1'b1;
      end
    end else if (syn != '0) begin
      is_ue = 1'b1;
    end
    fix_data = extract(fix_cw);
    dec_data = is_ue ? extract(rd_cw) : fix_data;
  end

  assign lat_done  = (lat_q == '0);
  assign scrub_due = i_scrub_en && (ivl_q == SW'(SCRUB_INTERVAL - 1));
  assign rsp_fire  = (state_q == S_RD_WAIT) && lat_done;
  assign chk_fire  = rsp_fire || ((state_q == S_SC_WAIT) && lat_done);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = encode(fix_data);
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          if (i_req_we) begin
            mem_we    = 1'b1;
            mem_waddr = i_req_addr;
            mem_wdata = encode(i_req_wdata) ^ (i_inj_en ? i_inj_mask : '0);
          end else begin
            addr_d  = i_req_addr;
            lat_d   = LW'(READ_LATENCY - 1);
            state_d = S_RD_WAIT;
          end
        end else if (scrub_due) begin
          addr_d  = ptr_q;
          lat_d   = LW'(READ_LATENCY - 1);
          state_d = S_SC_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_done) begin
          rdata_d = dec_data;
          err_d   = {is_ue, is_ce};
          state_d = is_ce ? S_RD_WB : S_IDLE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_SC_WAIT: begin
        if (lat_done) begin
          state_d = is_ce ? S_SC_WB : S_IDLE;
          if (!is_ce) ptr_d = ptr_q + ADDR_WIDTH'(1);
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_RD_WB: begin
        mem_we  = 1'b1;
        state_d = S_IDLE;
      end
      S_SC_WB: begin
        mem_we  = 1'b1;
        ptr_d   = ptr_q + ADDR_WIDTH'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ivl_d = ivl_q;
    if (!i_scrub_en) ivl_d = '0;
    else if (state_q == S_IDLE) begin
      if (scrub_due) begin
        if (!i_req_valid) ivl_d = '0;
      end else begin
        ivl_d = ivl_q + SW'(1);
      end
    end
    ce_d = ce_q;
    ue_d = ue_q;
    if (i_cnt_clr) begin
      ce_d = '0;
      ue_d = '0;
    end else if (chk_fire) begin
      if (is_ce && (ce_q != '1)) ce_d = ce_q + CNT_WIDTH'(1);
      if (is_ue && (ue_q != '1)) ue_d = ue_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ptr_q   <= '0;
      lat_q   <= '0;
      ivl_q   <= '0;
      ce_q    <= '0;
      ue_q    <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      lat_q   <= lat_d;
      ivl_q   <= ivl_d;
      ce_q    <= ce_d;
      ue_q    <= ue_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_rsp_valid = rsp_fire;
  assign o_rsp_rdata = rsp_fire ? dec_data : rdata_q;
  assign o_rsp_err   = rsp_fire ? {is_ue, is_ce} : err_q;
  assign o_ce_count  = ce_q;
  assign o_ue_count  = ue_q;

endmodule

// File: tb/tb_ecc_scrub_mem_ctrl.sv
// Directed bench for ecc_scrub_mem_ctrl: a write/read vector table plus scrub, saturation and
// mid-read reset sequences.
module tb_ecc_scrub_mem_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int RL   = 2;
  localparam int SI   = 4;
  localparam int CNTW = 2;
  localparam int CW   = DW + $clog2(DW) + 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          inj_en = 1'b0;
  logic [CW-1:0] inj_mask = '0;
  logic          scrub_en = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_err;
  logic [CNTW-1:0] ce_count, ue_count;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;
  int exp_ce = 0;
  int exp_ue = 0;

  ecc_scrub_mem_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL),
    .SCRUB_INTERVAL(SI), .CNT_WIDTH(CNTW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_inj_en(inj_en), .i_inj_mask(inj_mask),
    .i_scrub_en(scrub_en), .i_cnt_clr(cnt_clr),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_ce_count(ce_count), .o_ue_count(ue_count), .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit          inj;
    logic [CW-1:0] mask;
    logic [DW-1:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " ce_count"}, 32'(ce_count), 32'(exp_ce));
    chk({tag, " ue_count"}, 32'(ue_count), 32'(exp_ue));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit inj, input logic [CW-1:0] m);
    @(negedge clk);
    chk("write ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    inj_en = inj; inj_mask = m;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; inj_en = 1'b0; inj_mask = '0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                         input logic [1:0] exp_e, input bit clr_on_rsp);
    bit got;
    int k;
    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    got = 1'b0;
    k = 1;
    while (!got && k <= RL + 3) begin
      if (rsp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk({tag, " rsp seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, " latency"}, 32'(k), 32'(RL));
      chk({tag, " rdata"}, 32'(rsp_rdata), 32'(exp_d));
      chk({tag, " err"}, 32'(rsp_err), 32'(exp_e));
      if (clr_on_rsp) cnt_clr = 1'b1;
      if (clr_on_rsp) begin
        exp_ce = 0;
        exp_ue = 0;
      end else if (exp_e == 2'b01) begin
        if (exp_ce < CMAX) exp_ce++;
      end else if (exp_e == 2'b10) begin
        if (exp_ue < CMAX) exp_ue++;
      end
      @(negedge clk);
      cnt_clr = 1'b0;
      chk({tag, " pulse"}, 32'(rsp_valid), 32'd0);
      chk({tag, " rdata hold"}, 32'(rsp_rdata), 32'(exp_d));
      chk({tag, " busy after rsp"}, 32'(busy), 32'(exp_e == 2'b01));
      chk_counts(tag);
      if (exp_e == 2'b01) begin
        @(negedge clk);
        chk({tag, " idle after wb"}, 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_ce = 0;
    exp_ue = 0;
    chk_counts("clear");
  endtask

  initial begin
    bit done, stray;
    vecs[0]  = '{1'b1, 5'd3,  8'hA5, 1'b0, 13'h0000, 8'hA5, 2'b00};
    vecs[1]  = '{1'b1, 5'd7,  8'h3C, 1'b1, 13'h0010, 8'h3C, 2'b01};
    vecs[2]  = '{1'b0, 5'd7,  8'h00, 1'b0, 13'h0000, 8'h3C, 2'b00};
    vecs[3]  = '{1'b1, 5'd9,  8'h5A, 1'b1, 13'h0003, 8'h5A, 2'b10};
    vecs[4]  = '{1'b0, 5'd9,  8'h00, 1'b0, 13'h0000, 8'h5A, 2'b10};
    vecs[5]  = '{1'b0, 5'd3,  8'h00, 1'b0, 13'h0000, 8'hA5, 2'b00};
    vecs[6]  = '{1'b1, 5'd31, 8'hFF, 1'b1, 13'h1000, 8'hFF, 2'b01};
    vecs[7]  = '{1'b0, 5'd31, 8'h00, 1'b0, 13'h0000, 8'hFF, 2'b00};
    vecs[8]  = '{1'b1, 5'd0,  8'h00, 1'b1, 13'h0008, 8'h00, 2'b01};
    vecs[9]  = '{1'b1, 5'd12, 8'h81, 1'b1, 13'h0001, 8'h81, 2'b01};
    vecs[10] = '{1'b1, 5'd5,  8'h96, 1'b1, 13'h0006, 8'h96, 2'b10};
    vecs[11] = '{1'b1, 5'd20, 8'h5A, 1'b0, 13'h0000, 8'h5A, 2'b00};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rdata", 32'(rsp_rdata), 32'd0);
    chk("reset err", 32'(rsp_err), 32'd0);
    chk_counts("reset");

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].inj, vecs[i].mask);
      do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err, 1'b0);
    end

    // background scrub repairs a parity-only error at address 0
    do_clr();
    do_write(5'd0, 8'h33, 1'b1, 13'h0001);
    @(negedge clk);
    scrub_en = 1'b1;
    done = 1'b0;
    stray = 1'b0;
    for (int c = 0; c < SI + RL + 1 && !done; c++) begin
      @(negedge clk);
      if (rsp_valid) stray = 1'b1;
      if (ce_count == 2'd1) done = 1'b1;
    end
    chk("scrub ce within bound", 32'(done), 32'd1);
    chk("scrub no rsp_valid", 32'(stray), 32'd0);
    scrub_en = 1'b0;
    exp_ce = 1;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("scrub returns idle", 32'(done), 32'd1);
    do_read("post-scrub", 5'd0, 8'h33, 2'b00, 1'b0);

    // counter saturation, then clear winning over a same-cycle CE
    do_clr();
    for (int n = 0; n < 4; n++) begin
      do_write(5'd14, 8'hC3, 1'b1, 13'h0010);
      do_read($sformatf("sat%0d", n), 5'd14, 8'hC3, 2'b01, 1'b0);
    end
    chk("saturated ce", 32'(ce_count), 32'(CMAX));
    do_write(5'd14, 8'hC3, 1'b1, 13'h0010);
    do_read("clr+ce", 5'd14, 8'hC3, 2'b01, 1'b1);

    // reset during RD_WAIT aborts the read
    do_write(5'd2, 8'h6E, 1'b1, 13'h0020);
    do_read("pre-reset ce", 5'd2, 8'h6E, 2'b01, 1'b0);
    do_write(5'd2, 8'h6E, 1'b1, 13'h0020);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    stray = 1'b0;
    #1;
    chk("reset mid-read busy", 32'(busy), 32'd0);
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) stray = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) stray = 1'b1;
    end
    exp_ce = 0;
    exp_ue = 0;
    chk("reset abort no rsp", 32'(stray), 32'd0);
    chk("reset abort ready", 32'(req_ready), 32'd1);
    chk("reset abort rdata", 32'(rsp_rdata), 32'd0);
    chk("reset abort err", 32'(rsp_err), 32'd0);
    chk_counts("reset abort");
    do_read("after abort", 5'd2, 8'h6E, 2'b01, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
